// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported DMEM with a
// 1-cycle read latency. Port 0 is the LSU, port 1 the loader/debug port.
// Each port has its own read FSM, so an outstanding read on one port never
// blocks the other.
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN - when defined, p0 wins every tie (no round-robin
//                            state); when undefined, ties alternate between
//                            ports starting with p0 after reset.
module dmem_arbiter #(
  parameter int unsigned ADDR_DMEM_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,

  // port 0 (LSU)
  input  logic                       p0_req_valid,
  input  logic                       p0_req_we,
  input  logic [3:0]                 p0_req_strb,
  input  logic [ADDR_DMEM_WIDTH-1:0] p0_req_addr,
  input  logic [31:0]                p0_req_wdata,
  output logic                       p0_req_ready,
  output logic                       p0_rsp_valid,
  input  logic                       p0_rsp_ready,
  output logic [31:0]                p0_rsp_rdata,

  // port 1 (loader / debug)
  input  logic                       p1_req_valid,
  input  logic                       p1_req_we,
  input  logic [3:0]                 p1_req_strb,
  input  logic [ADDR_DMEM_WIDTH-1:0] p1_req_addr,
  input  logic [31:0]                p1_req_wdata,
  output logic                       p1_req_ready,
  output logic                       p1_rsp_valid,
  input  logic                       p1_rsp_ready,
  output logic [31:0]                p1_rsp_rdata,

  // DMEM port
  output logic                       we_dmem,
  output logic [3:0]                 wstrb_dmem,
  output logic [ADDR_DMEM_WIDTH-1:0] addr_dmem,
  output logic [31:0]                din_dmem,
  input  logic [31:0]                dout_dmem
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RD_ISSUED = 2'd1,
    S_RSP_HOLD  = 2'd2
  } rd_state_t;

  rd_state_t           r_p0_state;
  rd_state_t           r_p1_state;
  logic [DATA_W-1:0]   r_p0_rdata;
  logic [DATA_W-1:0]   r_p1_rdata;

`ifndef DMEM_ARB_FIXED_PRIO_EN
  // 1 = p1 was granted last, so p0 takes the next tie
  logic                r_last_grant;
`endif

  logic                w_elig0;
  logic                w_elig1;
  logic                w_gnt0;
  logic                w_gnt1;

  // A port may compete only when it has no read in flight; nothing is
  // granted while reset is held.
  assign w_elig0 = p0_req_valid && (r_p0_state == S_IDLE) && !rst;
  assign w_elig1 = p1_req_valid && (r_p1_state == S_IDLE) && !rst;

  // Grant selection: single eligible port wins outright, ties resolved by
  // round-robin or fixed p0 priority.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_elig0 && w_elig1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      w_gnt0 = 1'b1;
`else
      w_gnt0 = r_last_grant;
      w_gnt1 = !r_last_grant;
`endif
    end else begin
      w_gnt0 = w_elig0;
      w_gnt1 = w_elig1;
    end
  end

  assign p0_req_ready = w_gnt0;
  assign p1_req_ready = w_gnt1;

  // DMEM command mux: granted port drives the memory, otherwise all zero.
  always_comb begin
    we_dmem    = 1'b0;
    wstrb_dmem = STRB_W'(0);
    addr_dmem  = ADDR_DMEM_WIDTH'(0);
    din_dmem   = DATA_W'(0);
    if (w_gnt0) begin
      we_dmem    = p0_req_we;
      wstrb_dmem = p0_req_strb;
      addr_dmem  = p0_req_addr;
      din_dmem   = p0_req_wdata;
    end else if (w_gnt1) begin
      we_dmem    = p1_req_we;
      wstrb_dmem = p1_req_strb;
      addr_dmem  = p1_req_addr;
      din_dmem   = p1_req_wdata;
    end
  end

`ifndef DMEM_ARB_FIXED_PRIO_EN
  // Remember which port was granted last for tie-breaking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_gnt0) begin
      r_last_grant <= 1'b0;
    end else if (w_gnt1) begin
      r_last_grant <= 1'b1;
    end
  end
`endif

  // Port 0 read FSM: issue, capture DMEM data one cycle later, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_state <= S_IDLE;
      r_p0_rdata <= DATA_W'(0);
    end else begin
      case (r_p0_state)
        S_IDLE: begin
          if (w_gnt0 && !p0_req_we) begin
            r_p0_state <= S_RD_ISSUED;
          end
        end
        S_RD_ISSUED: begin
          r_p0_rdata <= dout_dmem;
          r_p0_state <= S_RSP_HOLD;
        end
        S_RSP_HOLD: begin
          if (p0_rsp_ready) begin
            r_p0_state <= S_IDLE;
          end
        end
        default: begin
          r_p0_state <= S_IDLE;
        end
      endcase
    end
  end

  // Port 1 read FSM: same behaviour as port 0, fully independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1_state <= S_IDLE;
      r_p1_rdata <= DATA_W'(0);
    end else begin
      case (r_p1_state)
        S_IDLE: begin
          if (w_gnt1 && !p1_req_we) begin
            r_p1_state <= S_RD_ISSUED;
          end
        end
        S_RD_ISSUED: begin
          r_p1_rdata <= dout_dmem;
          r_p1_state <= S_RSP_HOLD;
        end
        S_RSP_HOLD: begin
          if (p1_rsp_ready) begin
            r_p1_state <= S_IDLE;
          end
        end
        default: begin
          r_p1_state <= S_IDLE;
        end
      endcase
    end
  end

  // Response valid follows the hold state; forced low while reset is held.
  assign p0_rsp_valid = (r_p0_state == S_RSP_HOLD) && !rst;
  assign p1_rsp_valid = (r_p1_state == S_RSP_HOLD) && !rst;
  assign p0_rsp_rdata = r_p0_rdata;
  assign p1_rsp_rdata = r_p1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: DMEM behavioural memory, a transaction-level
// reference model checked every cycle, directed scenarios with literal
// expectations, then randomized traffic.
module tb_dmem_arbiter;

  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [1:0]           req_valid;
  logic [1:0]           req_we;
  logic [1:0]           rsp_ready;
  logic [1:0][3:0]      req_strb;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][31:0]     req_wdata;

  logic                 p0_req_ready, p1_req_ready;
  logic                 p0_rsp_valid, p1_rsp_valid;
  logic [31:0]          p0_rsp_rdata, p1_rsp_rdata;
  logic                 we_dmem;
  logic [3:0]           wstrb_dmem;
  logic [AW-1:0]        addr_dmem;
  logic [31:0]          din_dmem;
  logic [31:0]          dout_dmem;

  dmem_arbiter #(.ADDR_DMEM_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req_valid (req_valid[0]),
    .p0_req_we    (req_we[0]),
    .p0_req_strb  (req_strb[0]),
    .p0_req_addr  (req_addr[0]),
    .p0_req_wdata (req_wdata[0]),
    .p0_req_ready (p0_req_ready),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_ready (rsp_ready[0]),
    .p0_rsp_rdata (p0_rsp_rdata),
    .p1_req_valid (req_valid[1]),
    .p1_req_we    (req_we[1]),
    .p1_req_strb  (req_strb[1]),
    .p1_req_addr  (req_addr[1]),
    .p1_req_wdata (req_wdata[1]),
    .p1_req_ready (p1_req_ready),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_ready (rsp_ready[1]),
    .p1_rsp_rdata (p1_rsp_rdata),
    .we_dmem      (we_dmem),
    .wstrb_dmem   (wstrb_dmem),
    .addr_dmem    (addr_dmem),
    .din_dmem     (din_dmem),
    .dout_dmem    (dout_dmem)
  );

  // DMEM: synchronous read, 1-cycle latency, byte-strobed write
  logic [31:0] mem [1024] = '{default: 32'h0};
  always @(posedge clk) begin
    if (we_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_dmem[b]) mem[addr_dmem][8*b +: 8] <= din_dmem[8*b +: 8];
      end
    end
    dout_dmem <= mem[addr_dmem];
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks each port's pending read as "granted in cycle N,
  // response shown from cycle N+2 until taken", plus a shadow memory image.
  logic [31:0] ref_mem [1024] = '{default: 32'h0};
  bit          m_pend  [2];
  int          m_due   [2];
  logic [31:0] m_data  [2];
  logic [31:0] m_rdata [2];
  bit          m_last = 1'b1;
  int          cyc    = 0;

  always @(negedge clk) begin : model
    bit [1:0] elig;
    bit [1:0] gnt;
    bit [1:0] vis;
    int       gp;
    for (int p = 0; p < 2; p++) begin
      elig[p] = !rst && req_valid[p] && !m_pend[p];
      vis[p]  = m_pend[p] && (cyc >= m_due[p]);
    end
    gnt = elig;
    if (elig == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      gnt = 2'b01;
`else
      gnt = m_last ? 2'b01 : 2'b10;
`endif
    end
    gp = gnt[1] ? 1 : 0;

    if (chk_en) begin
      check("p0_req_ready", 32'(p0_req_ready), 32'(gnt[0]));
      check("p1_req_ready", 32'(p1_req_ready), 32'(gnt[1]));
      check("p0_rsp_valid", 32'(p0_rsp_valid), 32'(vis[0] && !rst));
      check("p1_rsp_valid", 32'(p1_rsp_valid), 32'(vis[1] && !rst));
      check("p0_rsp_rdata", p0_rsp_rdata, m_rdata[0]);
      check("p1_rsp_rdata", p1_rsp_rdata, m_rdata[1]);
      if (gnt != 2'b00) begin
        check("we_dmem",    32'(we_dmem),    32'(req_we[gp]));
        check("wstrb_dmem", 32'(wstrb_dmem), 32'(req_strb[gp]));
        check("addr_dmem",  32'(addr_dmem),  32'(req_addr[gp]));
        check("din_dmem",   din_dmem,        req_wdata[gp]);
      end else begin
        check("idle dmem cmd", {21'(0), we_dmem, wstrb_dmem, 6'(0)} | 32'(addr_dmem) | din_dmem, 32'h0);
      end
    end

    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        m_pend[p]  = 1'b0;
        m_rdata[p] = 32'h0;
      end
      m_last = 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (vis[p] && rsp_ready[p]) m_pend[p] = 1'b0;
        else if (m_pend[p] && (cyc + 1 == m_due[p])) m_rdata[p] = m_data[p];
      end
      if (gnt != 2'b00) begin
        m_last = gnt[1];
        if (req_we[gp]) begin
          for (int b = 0; b < 4; b++) begin
            if (req_strb[gp][b]) ref_mem[req_addr[gp]][8*b +: 8] = req_wdata[gp][8*b +: 8];
          end
        end else begin
          m_pend[gp] = 1'b1;
          m_due[gp]  = cyc + 2;
          m_data[gp] = ref_mem[req_addr[gp]];
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    req_valid = 2'b00;
    req_we    = 2'b00;
    rsp_ready = 2'b11;
    for (int p = 0; p < 2; p++) begin
      req_strb[p]  = 4'h0;
      req_addr[p]  = AW'(0);
      req_wdata[p] = 32'h0;
    end
  endtask

  task automatic drv(input int p, input logic we, input logic [3:0] strb,
                     input logic [AW-1:0] addr, input logic [31:0] wd);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_strb[p]  = strb;
    req_addr[p]  = addr;
    req_wdata[p] = wd;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [5:0] exp_rd0, exp_rd1;
  logic [3:0] exp_wr0, exp_wr1;

  initial begin
    rst = 1'b1;
    set_idle();
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;

    // write then read back through p0
    drv(0, 1'b1, 4'hF, AW'(4), 32'hCAFEBABE);
    @(negedge clk);
    check("A write we_dmem", 32'(we_dmem), 32'd1);
    check("A write ready", 32'(p0_req_ready), 32'd1);
    step();
    set_idle();
    drv(0, 1'b0, 4'hF, AW'(4), 32'h0);
    @(negedge clk);
    check("A read ready", 32'(p0_req_ready), 32'd1);
    check("A read we_dmem", 32'(we_dmem), 32'd0);
    step();
    set_idle();
    @(negedge clk);
    check("A rsp_valid at N+1", 32'(p0_rsp_valid), 32'd0);
    step();
    @(negedge clk);
    check("A rsp_valid at N+2", 32'(p0_rsp_valid), 32'd1);
    check("A rdata", p0_rsp_rdata, 32'hCAFEBABE);
    step();

    // both ports reading every cycle
    do_reset();
    exp_rd0 = 6'b001001;
    exp_rd1 = 6'b010010;
    for (int i = 0; i < 6; i++) begin
      set_idle();
      drv(0, 1'b0, 4'hF, AW'(16), 32'h0);
      drv(1, 1'b0, 4'hF, AW'(32), 32'h0);
      @(negedge clk);
      check("B rd p0 grant", 32'(p0_req_ready), 32'(exp_rd0[i]));
      check("B rd p1 grant", 32'(p1_req_ready), 32'(exp_rd1[i]));
      step();
    end
    set_idle();
    repeat (3) step();

    // both ports writing every cycle: tie every cycle
    do_reset();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    exp_wr0 = 4'b1111;
    exp_wr1 = 4'b0000;
`else
    exp_wr0 = 4'b0101;
    exp_wr1 = 4'b1010;
`endif
    for (int i = 0; i < 4; i++) begin
      set_idle();
      drv(0, 1'b1, 4'hF, AW'(40 + i), 32'h1000 + 32'(i));
      drv(1, 1'b1, 4'hF, AW'(50 + i), 32'h2000 + 32'(i));
      @(negedge clk);
      check("B wr p0 grant", 32'(p0_req_ready), 32'(exp_wr0[i]));
      check("B wr p1 grant", 32'(p1_req_ready), 32'(exp_wr1[i]));
      step();
    end

    // p1 response held back while p0 keeps writing
    set_idle();
    drv(0, 1'b1, 4'hF, AW'(5), 32'hA5A50001);
    step();
    set_idle();
    drv(1, 1'b0, 4'hF, AW'(5), 32'h0);
    rsp_ready[1] = 1'b0;
    @(negedge clk);
    check("C p1 read grant", 32'(p1_req_ready), 32'd1);
    step();
    for (int i = 0; i < 6; i++) begin
      drv(0, 1'b1, 4'hF, AW'(8 + i), 32'h5000 + 32'(i));
      drv(1, 1'b0, 4'hF, AW'(5), 32'h0);
      rsp_ready[1] = 1'b0;
      @(negedge clk);
      check("C p1 ready held low", 32'(p1_req_ready), 32'd0);
      check("C p0 write granted", 32'(p0_req_ready), 32'd1);
      if (i > 0) begin
        check("C p1 rsp_valid held", 32'(p1_rsp_valid), 32'd1);
        check("C p1 rdata stable", p1_rsp_rdata, 32'hA5A50001);
      end
      step();
    end
    set_idle();
    step();
    step();

    // reset while a p0 read is in RD_ISSUED
    set_idle();
    drv(0, 1'b0, 4'hF, AW'(4), 32'h0);
    @(negedge clk);
    check("D read grant", 32'(p0_req_ready), 32'd1);
    step();
    set_idle();
    drv(0, 1'b1, 4'hF, AW'(60), 32'h1);
    drv(1, 1'b1, 4'hF, AW'(61), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    check("D no ready in reset", 32'({p1_req_ready, p0_req_ready}), 32'd0);
    check("D dmem idle in reset", 32'(we_dmem), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("D no rsp after reset", 32'(p0_rsp_valid), 32'd0);
    check("D p0 wins first tie", 32'(p0_req_ready), 32'd1);
    check("D p1 loses first tie", 32'(p1_req_ready), 32'd0);
    check("D rdata cleared", p0_rsp_rdata, 32'h0);
    step();
    @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    check("D second tie p1", 32'(p1_req_ready), 32'd0);
`else
    check("D second tie p1", 32'(p1_req_ready), 32'd1);
`endif
    check("D still no rsp", 32'(p0_rsp_valid), 32'd0);
    step();
    set_idle();
    step();

    // zero-strobe write leaves the word untouched
    drv(0, 1'b1, 4'hF, AW'(7), 32'h11223344);
    step();
    set_idle();
    drv(0, 1'b1, 4'h0, AW'(7), 32'hFFFFFFFF);
    @(negedge clk);
    check("E nop we_dmem", 32'(we_dmem), 32'd1);
    check("E nop wstrb", 32'(wstrb_dmem), 32'd0);
    check("E nop granted", 32'(p0_req_ready), 32'd1);
    step();
    set_idle();
    drv(0, 1'b0, 4'hF, AW'(7), 32'h0);
    step();
    set_idle();
    step();
    @(negedge clk);
    check("E rsp_valid", 32'(p0_rsp_valid), 32'd1);
    check("E rdata", p0_rsp_rdata, 32'h11223344);
    step();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < 2; p++) begin
        req_valid[p] = ($urandom_range(0, 3) != 0);
        req_we[p]    = 1'($urandom_range(0, 1));
        req_strb[p]  = 4'($urandom_range(0, 15));
        req_addr[p]  = AW'($urandom_range(0, 15));
        req_wdata[p] = $urandom;
        rsp_ready[p] = ($urandom_range(0, 2) != 0);
      end
      step();
    end
    rst = 1'b0;
    set_idle();
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
